// File: rtl/acc_seq_pkg.sv
// Shared types for the accumulation sequencer: state encoding, registered flag set,
// and index-width helper.
package acc_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic clr;
    logic accum;
    logic latch;
    logic done;
    logic busy;
  } flags_t;

  function automatic flags_t decode_flags(input state_e s);
    flags_t f;
    f       = '0;
    f.clr   = (s == CLEAR);
    f.accum = (s == ACCUM);
    f.latch = (s == LATCH);
    f.done  = (s == DONE);
    f.busy  = (s != IDLE);
    return f;
  endfunction

  // A single-entry index still needs one bit of port width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_seq_if.sv
// Control/status bundle between the top-level controller (master) and the
// accumulation sequencer (slave).
interface acc_seq_if #(
  parameter int STEP_W  = 4,
  parameter int LAYER_W = 1
);
  import acc_seq_pkg::*;

  logic                 start;
  logic                 stall;
  logic                 abort;
  logic [STEP_W-1:0]    step;
  logic [LAYER_W-1:0]   layer;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 out_latch;
  logic                 busy;
  logic                 done;
  logic [STATE_W-1:0]   state;

  modport master (
    output start, stall, abort,
    input  step, layer, acc_clr, acc_en, out_latch, busy, done, state
  );

  modport slave (
    input  start, stall, abort,
    output step, layer, acc_clr, acc_en, out_latch, busy, done, state
  );

endinterface

// File: rtl/acc_seq_cnt.sv
// Bounded up-counter: saturates at max, synchronous clear has priority over increment.
module acc_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == max);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Accumulation sequencer for the MAC array: per-layer clear/accumulate/latch with
// start/done handshake, stall and abort. ACC_SEQ_AUTOLOOP_EN makes runs free-running.
//
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | clear accumulators, step = 0
//   ACCUM | accumulate one operand per non-stalled cycle
//   LATCH | latch layer result, advance layer or finish
//   DONE  | one-cycle end-of-run pulse
module acc_seq_ctrl
  import acc_seq_pkg::*;
#(
  parameter int STEPS  = 16,
  parameter int LAYERS = 2
) (
  input  logic       clk,
  input  logic       rst,
  acc_seq_if.slave   bus
);

  localparam int STEP_W  = idx_width(STEPS);
  localparam int LAYER_W = idx_width(LAYERS);
  localparam logic [STEP_W-1:0]  STEP_MAX  = STEP_W'(STEPS - 1);
  localparam logic [LAYER_W-1:0] LAYER_MAX = LAYER_W'(LAYERS - 1);

  state_e               state_q;
  state_e               state_d;
  flags_t               flags_q;
  logic                 step_clr;
  logic                 step_inc;
  logic                 step_at_max;
  logic                 layer_clr;
  logic                 layer_inc;
  logic                 layer_at_max;
  logic [STEP_W-1:0]    step_cnt;
  logic [LAYER_W-1:0]   layer_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= decode_flags(state_d);
    end
  end

  always_comb begin
    state_d   = state_q;
    step_inc  = 1'b0;
    layer_inc = 1'b0;
    step_clr  = 1'b0;
    layer_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = ACCUM;
      end
      ACCUM: begin
        if (!bus.stall) begin
          if (step_at_max) state_d = LATCH;
          else             step_inc = 1'b1;
        end
      end
      LATCH: begin
        if (layer_at_max) begin
          state_d = DONE;
        end else begin
          layer_inc = 1'b1;
          state_d   = CLEAR;
        end
      end
      DONE: begin
`ifdef ACC_SEQ_AUTOLOOP_EN
        state_d = CLEAR;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d   = IDLE;
      step_inc  = 1'b0;
      layer_inc = 1'b0;
    end

    // step keeps its last value through LATCH; layer survives every CLEAR of a run
    step_clr  = (state_d != ACCUM) && (state_d != LATCH);
    layer_clr = (state_d == IDLE) || (state_d == DONE);
  end

  acc_seq_cnt #(.W(STEP_W)) u_step_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (step_clr),
    .inc    (step_inc),
    .max    (STEP_MAX),
    .cnt    (step_cnt),
    .at_max (step_at_max)
  );

  acc_seq_cnt #(.W(LAYER_W)) u_layer_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (layer_clr),
    .inc    (layer_inc),
    .max    (LAYER_MAX),
    .cnt    (layer_cnt),
    .at_max (layer_at_max)
  );

  assign bus.state     = state_q;
  assign bus.step      = step_cnt;
  assign bus.layer     = layer_cnt;
  assign bus.acc_clr   = flags_q.clr;
  // operand validity is only known in the current cycle, so gate the registered ACCUM flag
  assign bus.acc_en    = flags_q.accum & ~bus.stall;
  assign bus.out_latch = flags_q.latch;
  assign bus.busy      = flags_q.busy;
  assign bus.done      = flags_q.done;

endmodule
